// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU operation sequencer and the ALU it drives:
// opcode constants, the default operand width and the sequencer FSM states.
package alu_pkg;

  // Default operand / result width.
  localparam int DATA_W_DEFAULT = 4;

  // ALU opcodes. 3'b110 and 3'b111 are unused; the ALU answers them with 0.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;

  // Sequencer FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_4bit.sv
// alu_4bit
// Purely combinational 4-bit ALU driven by the sequencer.
// Ports:
//   a_i, b_i  - operands
//   con_i     - opcode (see alu_pkg)
//   result_o  - 4-bit result
//   carry_o   - carry out of ADD, borrow out of SUB, 0 otherwise
module alu_4bit
  import alu_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [2:0] con_i,
  output logic [3:0] result_o,
  output logic       carry_o
);

  logic [4:0] sum;

  // Fifth bit carries the ADD carry or the SUB borrow.
  always_comb begin
    sum = 5'b0;
    case (con_i)
      OP_ADD:  sum = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  sum = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  sum = {1'b0, a_i & b_i};
      OP_OR:   sum = {1'b0, a_i | b_i};
      OP_XOR:  sum = {1'b0, a_i ^ b_i};
      OP_NOT:  sum = {1'b0, ~a_i};
      default: sum = 5'b0;
    endcase
  end

  assign result_o = sum[3:0];
  assign carry_o  = sum[4];

endmodule

// File: rtl/cmd_fifo.sv
// cmd_fifo
// Synchronous FIFO holding packed commands for the sequencer.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset; empties the FIFO
//   push_i   - write wdata_i at the tail (ignored when full)
//   wdata_i  - entry to write
//   pop_i    - drop the head entry (ignored when empty)
//   rdata_o  - head entry, valid while empty_o is low
//   full_o   - FIFO holds DEPTH entries
//   empty_o  - FIFO holds no entries
//   ready_o  - registered not-full flag; low during reset
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ready_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign ready_o = ready_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH (a power of two).
  // ready_q follows the post-edge occupancy, so a pop cannot raise it early.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d != CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Queues ALU commands in a FIFO, issues them one at a time to an external
// combinational ALU, and presents each captured result with a valid/ready
// handshake.
// Ports:
//   clk, rst_n              - clock and synchronous active-low reset
//   cmd_valid/cmd_ready     - command handshake
//   cmd_a, cmd_b, cmd_op    - command operands and opcode
//   alu_a, alu_b, alu_con   - operands/opcode driven to the ALU
//   alu_result, alu_carry   - ALU response
//   rsp_valid/rsp_ready     - response handshake
//   rsp_result, rsp_carry,
//   rsp_op                  - captured result, carry and echoed opcode
//   busy                    - FIFO non-empty or FSM not idle
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [2:0]        cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_con,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic [2:0]        rsp_op,
  output logic              busy
);

  localparam int CMD_W = 3 + 2 * DATA_W;

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [2:0]        alu_con_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_carry_q;
  logic [2:0]        rsp_op_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic              capture;

  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty, fifo_ready;
  logic [CMD_W-1:0]  fifo_head;

  // cmd_ready already implies not full; the live flag is a second guard so a
  // command can never be dropped silently.
  assign fifo_push = cmd_valid && fifo_ready && !fifo_full;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i ({cmd_op, cmd_a, cmd_b}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .ready_o (fifo_ready)
  );

  // Next-state logic. A response handshake with more work queued pops the
  // next command on the same edge, giving one response every two cycles.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    fifo_pop    = 1'b0;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        capture     = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // ALU operands move only on a pop; response fields only on capture, so
  // both hold steady while the downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rsp_valid_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_con_q    <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_op_q     <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      if (fifo_pop) begin
        {alu_con_q, alu_a_q, alu_b_q} <= fifo_head;
      end
      if (capture) begin
        rsp_result_q <= alu_result;
        rsp_carry_q  <= alu_carry;
        rsp_op_q     <= alu_con_q;
      end
    end
  end

  assign cmd_ready  = fifo_ready;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_con    = alu_con_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_op     = rsp_op_q;
  assign busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer with an alu_4bit on its ALU port.
// Expected responses are pushed to a queue when a command is accepted and
// popped when the sequencer presents a response.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = 4'h0;
  logic [3:0] cmd_b = 4'h0;
  logic [2:0] cmd_op = 3'b000;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_con;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic [2:0] rsp_op;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected response packed as {op[2:0], carry, result[3:0]}.
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(
    .DATA_W (4),
    .DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_con    (alu_con),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_op     (rsp_op),
    .busy       (busy)
  );

  alu_4bit u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .con_i    (alu_con),
    .result_o (alu_result),
    .carry_o  (alu_carry)
  );

  // Reference behaviour of the ALU as seen through the sequencer.
  function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {1'b0, ~a};
      default: r = 5'd0;
    endcase
    return {op, r};
  endfunction

  // Offer one command; entered and left just after a rising edge.
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input int limit, output bit ok);
    ok = 1'b0;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        exp_q.push_back(model(op, a, b));
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_ready got %b want 0", cmd_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++;
    if ({alu_a, alu_b, alu_con} !== 11'd0) begin
      errors++; $display("[TB] FAIL reset_alu got a=%h b=%h con=%b want all 0", alu_a, alu_b, alu_con);
    end
    checks++;
    if ({rsp_result, rsp_carry, rsp_op} !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_rsp got res=%h c=%b op=%b want all 0", rsp_result, rsp_carry, rsp_op);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_before_edge got %b want 0", cmd_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_edge got %b want 1", cmd_ready); end
  endtask

  // ADD, SUB with borrow, unused opcode 111 and NOT, each with its latency.
  task automatic test_single_ops();
    logic [2:0] t_op [4];
    logic [3:0] t_a [4];
    logic [3:0] t_b [4];
    logic [3:0] t_res [4];
    logic       t_c [4];
    bit         ok;
    int         lat;
    logic [7:0] exp;
    t_op[0] = 3'b000; t_a[0] = 4'h9; t_b[0] = 4'h8; t_res[0] = 4'h1; t_c[0] = 1'b1;
    t_op[1] = 3'b001; t_a[1] = 4'h3; t_b[1] = 4'h5; t_res[1] = 4'hE; t_c[1] = 1'b1;
    t_op[2] = 3'b111; t_a[2] = 4'hF; t_b[2] = 4'hF; t_res[2] = 4'h0; t_c[2] = 1'b0;
    t_op[3] = 3'b101; t_a[3] = 4'h5; t_b[3] = 4'h0; t_res[3] = 4'hA; t_c[3] = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(t_op[i], t_a[i], t_b[i], 10, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL op%0d_accept got 0 want 1", i); end
      // lat counts rising edges from the accepting edge up to rsp_valid.
      lat = 1;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (rsp_valid) break;
        @(posedge clk);
        #1;
        lat++;
      end
      checks++;
      if (lat != 3) begin errors++; $display("[TB] FAIL op%0d_latency got %0d want 3", i, lat); end
      checks++;
      if (rsp_result !== t_res[i]) begin errors++; $display("[TB] FAIL op%0d_result got %h want %h", i, rsp_result, t_res[i]); end
      checks++;
      if (rsp_carry !== t_c[i]) begin errors++; $display("[TB] FAIL op%0d_carry got %b want %b", i, rsp_carry, t_c[i]); end
      checks++;
      if (rsp_op !== t_op[i]) begin errors++; $display("[TB] FAIL op%0d_rsp_op got %b want %b", i, rsp_op, t_op[i]); end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if ({rsp_op, rsp_carry, rsp_result} !== exp) begin
        errors++; $display("[TB] FAIL op%0d_scoreboard got %h want %h", i, {rsp_op, rsp_carry, rsp_result}, exp);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL op%0d_valid_clear got %b want 0", i, rsp_valid); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    bit         ok;
    int         acc;
    int         got;
    logic [7:0] snap;
    logic [7:0] exp;
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(3'(i), 4'(i * 5 + 3), 4'(i * 3 + 2), 8, ok);
      if (ok) acc++;
    end
    checks++;
    if (acc != 5) begin errors++; $display("[TB] FAIL bp_accepted got %0d want 5", acc); end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_cmd_ready got %b want 0", cmd_ready); end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_rsp_valid got %b want 1", rsp_valid); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy got %b want 1", busy); end
    snap = {rsp_op, rsp_carry, rsp_result};
    repeat (4) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_op, rsp_carry, rsp_result} !== {1'b1, snap}) begin
      errors++; $display("[TB] FAIL bp_stable got v=%b %h want v=1 %h", rsp_valid, {rsp_op, rsp_carry, rsp_result}, snap);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 40 && got < 5; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if ({rsp_op, rsp_carry, rsp_result} !== exp) begin
          errors++; $display("[TB] FAIL bp_rsp%0d got %h want %h", got, {rsp_op, rsp_carry, rsp_result}, exp);
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (got != 5) begin errors++; $display("[TB] FAIL bp_rsp_count got %0d want 5", got); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL bp_leftover got %0d want 0", exp_q.size()); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_drained got busy=%b v=%b want 0 0", busy, rsp_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int  times [$];
    int  got;
    rsp_ready = 1'b1;
    got = 0;
    fork
      begin
        bit ok;
        for (int i = 0; i < 8; i++) begin
          send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 20, ok);
          checks++;
          if (!ok) begin errors++; $display("[TB] FAIL b2b_accept%0d got 0 want 1", i); end
        end
      end
      begin
        logic [7:0] exp;
        for (int n = 0; n < 120 && got < 8; n++) begin
          @(negedge clk);
          if (rsp_valid) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if ({rsp_op, rsp_carry, rsp_result} !== exp) begin
              errors++; $display("[TB] FAIL b2b_rsp%0d got %h want %h", got, {rsp_op, rsp_carry, rsp_result}, exp);
            end
            times.push_back(cyc);
            got++;
          end
          @(posedge clk);
          #1;
        end
      end
    join
    rsp_ready = 1'b0;
    checks++;
    if (got != 8) begin errors++; $display("[TB] FAIL b2b_count got %0d want 8", got); end
    for (int i = 1; i < times.size(); i++) begin
      checks++;
      if (times[i] - times[i-1] != 2) begin
        errors++; $display("[TB] FAIL b2b_gap%0d got %0d want 2", i, times[i] - times[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int stale;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(3'b000, 4'(i + 1), 4'(i + 2), 10, ok);
    end
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || !busy) begin errors++; $display("[TB] FAIL mid_wait_rsp got v=%b busy=%b want 1 1", seen, busy); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b000) begin
      errors++; $display("[TB] FAIL mid_flags got v=%b busy=%b rdy=%b want 0 0 0", rsp_valid, busy, cmd_ready);
    end
    checks++;
    if ({alu_a, alu_b, alu_con, rsp_result, rsp_carry, rsp_op} !== 19'd0) begin
      errors++; $display("[TB] FAIL mid_outputs got %h want 0", {alu_a, alu_b, alu_con, rsp_result, rsp_carry, rsp_op});
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || busy) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("[TB] FAIL mid_stale got %0d want 0", stale); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got %b want 1", cmd_ready); end
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
- REQ-001 The block SHALL use parameter DATA_W, default 4, as the operand and result width.
- REQ-002 The block SHALL use parameter DEPTH, default 4 (power of two, at least 2), as the command FIFO depth.
- REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
- REQ-005 The block SHALL have port cmd_valid, input, 1 bit: the upstream command is valid.
- REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
- REQ-007 The block SHALL have ports cmd_a and cmd_b, input, DATA_W bits each: the command operands.
- REQ-008 The block SHALL have port cmd_op, input, 3 bits: the ALU opcode.
- REQ-009 The block SHALL have ports alu_a and alu_b, output, DATA_W bits each: the operands driven to the combinational ALU.
- REQ-010 The block SHALL have port alu_con, output, 3 bits: the opcode driven to the ALU.
- REQ-011 The block SHALL have ports alu_result, input, DATA_W bits, and alu_carry, input, 1 bit: the ALU response.
- REQ-012 The block SHALL have port rsp_valid, output, 1 bit: a response is available.
- REQ-013 The block SHALL have port rsp_ready, input, 1 bit: downstream accepts the response.
- REQ-014 The block SHALL have ports rsp_result, output, DATA_W bits, rsp_carry, output, 1 bit, and rsp_op, output, 3 bits: the captured result, carry and echoed opcode.
- REQ-015 The block SHALL have port busy, output, 1 bit: high when the FIFO is non-empty or the FSM is not in IDLE.

Function
- REQ-016 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high; {cmd_op, cmd_a, cmd_b} is then written to the FIFO tail.
- REQ-017 cmd_ready SHALL equal the registered FIFO not-full state; a pop in the same cycle SHALL NOT raise cmd_ready in that cycle.
- REQ-018 The FIFO SHALL support simultaneous push and pop when it is neither empty nor full, with the count unchanged.
- REQ-019 FIFO pointers SHALL wrap modulo DEPTH.
- REQ-020 The FSM SHALL have three states: IDLE, ISSUE and WAIT_RSP.
- REQ-021 In IDLE with the FIFO non-empty, the block SHALL pop the head, register it onto alu_a, alu_b and alu_con, and go to ISSUE.
- REQ-022 In ISSUE, the block SHALL capture alu_result, alu_carry and alu_con into rsp_result, rsp_carry and rsp_op at the end of the cycle, set rsp_valid, and go to WAIT_RSP.
- REQ-023 In WAIT_RSP, rsp_valid and all rsp_* outputs SHALL hold stable until rsp_ready is high.
- REQ-024 On the rsp_ready handshake, rsp_valid SHALL clear; if the FIFO is non-empty the block SHALL pop and go to ISSUE in the same edge, otherwise it SHALL go to IDLE.
- REQ-025 alu_a, alu_b and alu_con SHALL change only on a pop and SHALL hold their last values otherwise.
- REQ-026 The latency from command acceptance into an empty, idle block to rsp_valid high SHALL be 3 cycles.
- REQ-027 When rsp_ready is held high, throughput SHALL be one response per 2 cycles.
- REQ-028 Opcodes 110 and 111 SHALL be issued unchanged, with the ALU response captured as-is (expected result 0, carry 0).
- REQ-029 The block SHALL perform no arithmetic; the carry SHALL be passed through unmodified, including the borrow on subtraction.

Reset
- REQ-030 While rst_n is low at a clock edge: the FIFO SHALL empty, the FSM SHALL enter IDLE, rsp_valid SHALL be 0, and cmd_ready SHALL be 0.
- REQ-031 While rst_n is low at a clock edge, alu_a, alu_b, alu_con, rsp_result, rsp_carry, rsp_op and busy SHALL all be 0.
- REQ-032 cmd_ready SHALL rise on the first edge after rst_n goes high.
- REQ-033 A reset during ISSUE or WAIT_RSP SHALL discard both the in-flight command and all queued commands, with no response produced.

Structure
- REQ-034 Shared package alu_pkg SHALL hold the opcode constants (OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_NOT=101), the default DATA_W, and the FSM state encoding.
- REQ-035 The FIFO SHALL be the sub-module cmd_fifo (synchronous, parameterised on width and depth, with full/empty flags).
- REQ-036 The ALU SHALL be external to this block; the bench SHALL connect an alu_4bit instance to the alu_* ports.

Verification
- REQ-037 The bench SHALL cover ADD: op=000, a=9, b=8 -> rsp_result=1, rsp_carry=1, rsp_op=000, rsp_valid 3 cycles after acceptance.
- REQ-038 The bench SHALL cover SUB: op=001, a=3, b=5 -> rsp_result=1110, rsp_carry=1.
- REQ-039 The bench SHALL cover backpressure: rsp_ready=0 with 6 commands offered -> 5 accepted (1 in flight, 4 queued), cmd_ready low, rsp_* stable; then rsp_ready=1 -> 5 responses in order with correct values.
- REQ-040 The bench SHALL cover op=111, a=F, b=F -> rsp_result=0, rsp_carry=0; and op=101, a=0101 -> rsp_result=1010, rsp_carry=0.
- REQ-041 The bench SHALL cover reset in WAIT_RSP with 2 commands queued -> next cycle rsp_valid=0, busy=0, all outputs 0, and no stale response after reset releases.
- REQ-042 The bench SHALL cover back-to-back streaming of 8 commands with rsp_ready=1 -> 8 ordered responses, one every 2 cycles, with FIFO pointer wrap exercised.
